// File: rtl/uart_tx_report_pkg.sv
// Shared widths, rates and frame packing for the DDS settings report link.
package uart_tx_report_pkg;

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

    localparam int BN_ST = 2;
    localparam int BN_F  = 15;
    localparam int BN_O  = 8;
    localparam int BN_A  = 11;

    localparam int BYTES_ST = 1;
    localparam int BYTES_F  = 2;
    localparam int BYTES_O  = 1;
    localparam int BYTES_A  = 2;
    localparam int BN       = BYTES_ST + BYTES_F + BYTES_O + BYTES_A;
    localparam int FRAME_W  = BN * 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Same byte layout the receive parser expects. Byte0 sits in the low
    // byte so the frame can be shifted out from bit 0 one byte at a time.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [BN_ST-1:0] st,
        input logic [BN_F-1:0]  f,
        input logic [BN_O-1:0]  o,
        input logic [BN_A-1:0]  a
    );
        logic [15:0] f16;
        logic [15:0] a16;
        f16 = 16'(f);
        a16 = 16'(a);
        return {a16[7:0], a16[15:8], o, f16[7:0], f16[15:8], 8'(st)};
    endfunction

endpackage

// File: rtl/uart_tx_report_if.sv
// Request/settings/line bundle between the settings owner and the report transmitter.
interface uart_tx_report_if;
    import uart_tx_report_pkg::*;

    logic             send_req;
    logic [BN_ST-1:0] signal_type;
    logic [BN_F-1:0]  frequency;
    logic [BN_O-1:0]  offset;
    logic [BN_A-1:0]  amplitude;
    logic             tx;
    logic             busy;
    logic             tx_done;

    modport master (
        output send_req, signal_type, frequency, offset, amplitude,
        input  tx, busy, tx_done
    );

    modport slave (
        input  send_req, signal_type, frequency, offset, amplitude,
        output tx, busy, tx_done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser. A tx_start seen on the last stop-bit cycle
// chains straight into the next start bit, so bytes go out without a gap.
module uart_tx_byte
    import uart_tx_report_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       byte_done
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    data_reg, data_next;
    logic          tx_reg, tx_next;
    logic          bit_end;

    assign bit_end = (cnt_reg == CNT_LAST);

    // State, baud counter, data latch and the registered line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            tx_reg      <= tx_next;
        end
    end

    // Next-state logic; tx_next is the level the line shows in the next state.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = bit_end ? '0 : cnt_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        tx_next      = tx_reg;
        byte_done    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                tx_next  = 1'b1;
                if (tx_start) begin
                    state_next = ST_START;
                    data_next  = din;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                    tx_next      = data_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = data_reg[bit_idx_next];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    byte_done = 1'b1;
                    if (tx_start) begin
                        state_next = ST_START;
                        data_next  = din;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state_reg != ST_IDLE);

endmodule

// File: rtl/uart_tx_report.sv
// Frame sequencer: snapshots the DDS settings on request and feeds the six
// report bytes back-to-back into the byte serialiser.
module uart_tx_report
    import uart_tx_report_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_report_if.slave   bus
);

    localparam int         DIV       = CLK_FREQ / BAUD;
    localparam logic [2:0] LAST_BYTE = 3'(BN - 1);

    logic [FRAME_W-1:0] packed_frame;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [2:0]         byte_idx_reg, byte_idx_next;
    logic               busy_reg, busy_next;
    logic               tx_done_reg, tx_done_next;
    logic               tx_start;
    logic [7:0]         din;
    logic               byte_tx;
    logic               byte_busy;
    logic               byte_done;

    assign packed_frame = pack_frame(bus.signal_type, bus.frequency, bus.offset, bus.amplitude);

    uart_tx_byte #(
        .DIV (DIV)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .din       (din),
        .tx        (byte_tx),
        .tx_busy   (byte_busy),
        .byte_done (byte_done)
    );

    // Snapshot buffer, byte index and the frame-level busy / done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            busy_reg     <= 1'b0;
            tx_done_reg  <= 1'b0;
        end else begin
            shift_reg    <= shift_next;
            byte_idx_reg <= byte_idx_next;
            busy_reg     <= busy_next;
            tx_done_reg  <= tx_done_next;
        end
    end

    // Byte0 goes straight into the serialiser on the request cycle; the
    // remaining bytes are held in the shift buffer and popped on each byte_done.
    always_comb begin
        shift_next    = shift_reg;
        byte_idx_next = byte_idx_reg;
        busy_next     = busy_reg;
        tx_done_next  = 1'b0;
        tx_start      = 1'b0;
        din           = '0;
        if (!busy_reg) begin
            if (bus.send_req) begin
                tx_start      = 1'b1;
                din           = packed_frame[7:0];
                shift_next    = packed_frame >> 8;
                byte_idx_next = '0;
                busy_next     = 1'b1;
            end
        end else if (byte_done && byte_busy) begin
            if (byte_idx_reg < LAST_BYTE) begin
                tx_start      = 1'b1;
                din           = shift_reg[7:0];
                shift_next    = shift_reg >> 8;
                byte_idx_next = byte_idx_reg + 3'd1;
            end else begin
                busy_next    = 1'b0;
                tx_done_next = 1'b1;
            end
        end
    end

    assign bus.tx      = byte_tx;
    assign bus.busy    = busy_reg;
    assign bus.tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_report.sv
// Bench for the settings report transmitter, run with DIV = 16.
module tb_uart_tx_report;
    import uart_tx_report_pkg::*;

    localparam int TB_CLK_FREQ = 1_600_000;
    localparam int TB_BAUD     = 100_000;
    localparam int TB_DIV      = TB_CLK_FREQ / TB_BAUD;
    localparam int FRAME_CYC   = BN * 10 * TB_DIV;

    localparam int K_NONE    = 0;
    localparam int K_SNAP    = 1;
    localparam int K_BUSYREQ = 2;
    localparam int K_HOLD    = 3;

    typedef struct {
        logic [1:0]  st;
        logic [14:0] f;
        logic [7:0]  o;
        logic [10:0] a;
        logic [47:0] exp;   // byte0 in bits 47:40
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_report_if bus();

    uart_tx_report #(
        .CLK_FREQ (TB_CLK_FREQ),
        .BAUD     (TB_BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   asrt_fail = 0;
    logic samp [FRAME_CYC];
    vec_t vecs [4];

    // Line-level timing watch: inside a frame tx may only change on a
    // 16-cycle boundary and every 160th cycle must be a start bit.
    int   fc        = 0;
    logic busy_prev = 1'b0;
    logic tx_prev   = 1'b1;
    always @(negedge clk) begin
        if (!rst && bus.busy === 1'b1) begin
            fc = (busy_prev === 1'b1) ? fc + 1 : 0;
            if (fc % TB_DIV != 0) begin
                assert (bus.tx === tx_prev) else begin
                    asrt_fail++;
                    $display("FAIL bit_hold: tx at frame cycle %0d got %b required %b", fc, bus.tx, tx_prev);
                end
            end
            if (fc % (10 * TB_DIV) == 0) begin
                assert (bus.tx === 1'b0) else begin
                    asrt_fail++;
                    $display("FAIL start_gap: tx at frame cycle %0d got %b required 0", fc, bus.tx);
                end
            end
        end
        busy_prev = bus.busy;
        tx_prev   = bus.tx;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [47:0] ref_frame(input int st, input int f, input int o, input int a);
        int          b [6];
        logic [47:0] r;
        b[0] = st;
        b[1] = f / 256;
        b[2] = f % 256;
        b[3] = o;
        b[4] = a / 256;
        b[5] = a % 256;
        r = '0;
        for (int i = 0; i < 6; i++) r = {r[39:0], 8'(b[i])};
        return r;
    endfunction

    // Expected line level k cycles after the first start-bit cycle.
    function automatic logic ref_level(input logic [47:0] fr, input int k);
        int         bitpos;
        int         bi;
        int         pos;
        logic [7:0] by;
        bitpos = k / TB_DIV;
        bi     = bitpos / 10;
        pos    = bitpos % 10;
        by     = fr[47 - 8*bi -: 8];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    task automatic set_fields(input int st, input int f, input int o, input int a);
        bus.signal_type = 2'(st);
        bus.frequency   = 15'(f);
        bus.offset      = 8'(o);
        bus.amplitude   = 11'(a);
    endtask

    // Called at a negedge; returns at the negedge of the first start-bit cycle.
    task automatic launch(input string tag);
        check({tag, " busy_before_req"}, 64'(bus.busy), 64'd0);
        bus.send_req = 1'b1;
        @(negedge clk);
        bus.send_req = 1'b0;
        check({tag, " busy_after_req"}, 64'(bus.busy), 64'd1);
        check({tag, " first_start_bit"}, 64'(bus.tx), 64'd0);
    endtask

    task automatic capture(input logic [47:0] exp, input int kind, input string tag);
        int         busy_err = 0;
        int         done_err = 0;
        int         wave_err = 0;
        logic [7:0] got [6];
        for (int k = 0; k < FRAME_CYC; k++) begin
            samp[k] = bus.tx;
            if (bus.busy !== 1'b1) busy_err++;
            if (bus.tx_done !== 1'b0) done_err++;
            case (kind)
                K_SNAP:    if (k == 300) set_fields(0, 'h7FFF, 0, 0);
                K_BUSYREQ: begin
                    if (k == 100 || k == 500) bus.send_req = 1'b1;
                    if (k == 101 || k == 501) bus.send_req = 1'b0;
                end
                K_HOLD:    if (k == 900) bus.send_req = 1'b1;
                default:   ;
            endcase
            @(negedge clk);
        end
        check({tag, " tx_done_at_960"}, 64'(bus.tx_done), 64'd1);
        check({tag, " busy_low_at_960"}, 64'(bus.busy), 64'd0);
        check({tag, " busy_held"}, 64'(busy_err), 64'd0);
        check({tag, " no_early_done"}, 64'(done_err), 64'd0);
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 8; i++) got[b][i] = samp[b*10*TB_DIV + (1+i)*TB_DIV + TB_DIV/2];
            check($sformatf("%s byte%0d", tag, b), 64'(got[b]), 64'(exp[47 - 8*b -: 8]));
        end
        for (int k = 0; k < FRAME_CYC; k++)
            if (samp[k] !== ref_level(exp, k)) wave_err++;
        check({tag, " waveform"}, 64'(wave_err), 64'd0);
        $display("frame %s: %02h %02h %02h %02h %02h %02h", tag,
                 got[0], got[1], got[2], got[3], got[4], got[5]);
        @(negedge clk);
        if (kind == K_HOLD) begin
            check({tag, " restart_start_bit"}, 64'(bus.tx), 64'd0);
            check({tag, " restart_busy"}, 64'(bus.busy), 64'd1);
            bus.send_req = 1'b0;
        end else begin
            check({tag, " done_one_cycle"}, 64'(bus.tx_done), 64'd0);
            check({tag, " idle_high"}, 64'(bus.tx), 64'd1);
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) bad++;
        end
        check({tag, " idle_cycles_bad"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [47:0] e;
        int          st, f, o, a;

        vecs[0] = '{2'd2, 15'h1234, 8'h80, 11'h3FF, 48'h02_12_34_80_03_FF};
        vecs[1] = '{2'd0, 15'h7FFF, 8'h00, 11'h000, 48'h00_7F_FF_00_00_00};
        vecs[2] = '{2'd3, 15'h0000, 8'hFF, 11'h7FF, 48'h03_00_00_FF_07_FF};
        vecs[3] = '{2'd1, 15'h00A5, 8'h01, 11'h400, 48'h01_00_A5_01_04_00};

        bus.send_req = 1'b0;
        set_fields(0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", 64'(bus.tx), 64'd1);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset tx_done", 64'(bus.tx_done), 64'd0);
        rst = 1'b0;
        idle_check(2000, "reset_idle");

        // Table vectors
        for (int v = 0; v < 4; v++) begin
            set_fields(vecs[v].st, vecs[v].f, vecs[v].o, vecs[v].a);
            launch($sformatf("vec%0d", v));
            capture(vecs[v].exp, K_NONE, $sformatf("vec%0d", v));
        end

        // Inputs changed mid-frame must not leak into the frame in flight
        set_fields(vecs[0].st, vecs[0].f, vecs[0].o, vecs[0].a);
        launch("snap_a");
        capture(vecs[0].exp, K_SNAP, "snap_a");
        launch("snap_b");
        capture(vecs[1].exp, K_NONE, "snap_b");

        // Requests while busy are dropped
        set_fields(vecs[2].st, vecs[2].f, vecs[2].o, vecs[2].a);
        launch("busyreq");
        capture(vecs[2].exp, K_BUSYREQ, "busyreq");
        idle_check(200, "busyreq_after");

        // Request held through tx_done restarts on the following cycle
        set_fields(vecs[3].st, vecs[3].f, vecs[3].o, vecs[3].a);
        launch("hold1");
        capture(vecs[3].exp, K_HOLD, "hold1");
        capture(vecs[3].exp, K_NONE, "hold2");

        // Asynchronous reset during byte 3 data bits
        set_fields(vecs[0].st, vecs[0].f, vecs[0].o, vecs[0].a);
        launch("rst_mid");
        repeat (520) @(negedge clk);
        check("rst_mid busy_before_reset", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid async tx", 64'(bus.tx), 64'd1);
        check("rst_mid async busy", 64'(bus.busy), 64'd0);
        check("rst_mid async tx_done", 64'(bus.tx_done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check(20, "rst_mid_idle");
        st = $urandom_range(0, 3);
        f  = $urandom_range(0, 32767);
        o  = $urandom_range(0, 255);
        a  = $urandom_range(0, 2047);
        set_fields(st, f, o, a);
        launch("rst_after");
        capture(ref_frame(st, f, o, a), K_NONE, "rst_after");

        // Random settings against the reference model
        for (int r = 0; r < 6; r++) begin
            st = $urandom_range(0, 3);
            f  = $urandom_range(0, 32767);
            o  = $urandom_range(0, 255);
            a  = $urandom_range(0, 2047);
            e  = ref_frame(st, f, o, a);
            set_fields(st, f, o, a);
            launch($sformatf("rand%0d", r));
            capture(e, K_NONE, $sformatf("rand%0d", r));
        end

        check("bit_timing_watch", 64'(asrt_fail), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
